// File: rtl/gfx256_pkg.sv
// ---------------------------------------------------------------------------
// gfx256_pkg
//   Shared types and constants for the gfx256 memory-side blocks.
//   Contents:
//     rdarb_state_e    - read arbiter FSM states
//     RDARB_MAXREQ     - largest supported number of read clients
//     rdarb_next_idx() - modulo-n increment used for the round-robin pointer
// ---------------------------------------------------------------------------
package gfx256_pkg;

    typedef enum logic [1:0] {
        RDARB_IDLE     = 2'd0,
        RDARB_WAIT_ACK = 2'd1,
        RDARB_HIT      = 2'd2
    } rdarb_state_e;

    localparam int RDARB_MAXREQ = 8;

    // (idx + 1) mod n without a divider; idx is always < n.
    function automatic int rdarb_next_idx(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/gfx256_rr_pick.sv
// ---------------------------------------------------------------------------
// gfx256_rr_pick
//   Combinational rotate-priority encoder. Searches req starting at ptr and
//   wrapping modulo NREQ; the first set bit wins.
//   Ports:
//     req   in  NREQ   request vector
//     ptr   in  PTR_W  index with highest priority this cycle (< NREQ)
//     grant out NREQ   one-hot winner, all zero when nothing requests
//     any   out 1      at least one request is set
// ---------------------------------------------------------------------------
module gfx256_rr_pick #(
    parameter int NREQ  = 3,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic             any
);

    // NOTE: every output of an always_comb is given a default before any
    // conditional assignment, so no path can leave it holding a value (no latch).
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            logic [PTR_W-1:0] idx;
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gfx256_rd_arbiter.sv
// ---------------------------------------------------------------------------
// gfx256_rd_arbiter
//   Round-robin arbiter sharing the single 256-bit wishbone reader port
//   between NREQ read clients (0 = clip z-read, 1 = fragment texture read,
//   2 = blender destination read). One outstanding read at a time. Clients
//   hold req until a one-cycle ack; data is valid in the ack cycle.
//
//   Optional feature macro: GFX256_RDARB_CACHE_EN
//     defined   - one-line read cache (tag, 256-bit line, valid); a picked
//                 client hitting the line is acked from the cache in a
//                 single HIT cycle without touching the reader port.
//     undefined - no cache; inv_i is unused and data_o = m_data_i.
//
//   Ports:
//     clk_i        in   system clock
//     rst_ni       in   synchronous reset, active low
//     req_i        in   [NREQ]        per-client read request
//     addr_i       in   [NREQ][31:5]  per-client 32-byte line address
//     sel_i        in   [NREQ][31:0]  per-client byte selects
//     ack_o        out  [NREQ]        per-client ack pulse
//     data_o       out  [255:0]       read data, valid when any ack_o bit is set
//     inv_i        in   invalidate the cached line
//     m_request_o  out  reader request
//     m_addr_o     out  [31:5] reader line address
//     m_sel_o      out  [31:0] reader byte selects
//     m_ack_i      in   reader ack, data valid
//     m_data_i     in   [255:0] reader data
//     m_busy_i     in   reader busy, do not raise a new request
// ---------------------------------------------------------------------------
module gfx256_rd_arbiter
    import gfx256_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0][31:5]  addr_i,
    input  logic [NREQ-1:0][31:0]  sel_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [255:0]           data_o,
    input  logic                   inv_i,
    output logic                   m_request_o,
    output logic [31:5]            m_addr_o,
    output logic [31:0]            m_sel_o,
    input  logic                   m_ack_i,
    input  logic [255:0]           m_data_i,
    input  logic                   m_busy_i
);

    localparam int PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > RDARB_MAXREQ) begin : g_nreq_range
        $error("gfx256_rd_arbiter: NREQ must be in 2..RDARB_MAXREQ");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    rdarb_state_e      state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  ptr_q,   ptr_d;
    logic              request_d;
    logic [31:5]       addr_d;
    logic [31:0]       sel_d;

    // -----------------------------------------------------------------------
    // Round-robin pick and index conversion
    // -----------------------------------------------------------------------
    logic [NREQ-1:0]   pick_grant;
    logic              pick_any;
    logic [PTR_W-1:0]  pick_idx;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic              pick_hit;

    gfx256_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    always_comb begin
        pick_idx  = '0;
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) pick_idx  = PTR_W'(i);
            if (grant_q[i])    grant_idx = PTR_W'(i);
        end
    end

    // The client after the one just served gets top priority next.
    assign ptr_next = PTR_W'(rdarb_next_idx(int'(grant_idx), NREQ));

    // -----------------------------------------------------------------------
    // Optional one-line cache
    // -----------------------------------------------------------------------
`ifdef GFX256_RDARB_CACHE_EN
    logic [31:5]  tag_q;
    logic [255:0] line_q;
    logic         valid_q;
    logic         fill;

    // Only acks belonging to our own outstanding read fill the line; a stray
    // ack after a mid-transaction reset carries no address we could trust.
    assign fill = (state_q == RDARB_WAIT_ACK) && m_ack_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
        end else if (inv_i) begin
            // Invalidate wins over a same-cycle fill: memory may have been
            // written after the reader sampled the returning line.
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
        end
    end

    // NOTE: the line storage has no reset; valid_q alone decides whether the
    // contents mean anything, so resetting 283 flops would buy nothing.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q  <= m_addr_o;
            line_q <= m_data_i;
        end
    end

    assign pick_hit = pick_any && valid_q && (addr_i[pick_idx] == tag_q);
    assign data_o   = (state_q == RDARB_HIT) ? line_q : m_data_i;
`else
    logic unused_inv;
    assign unused_inv = inv_i;
    assign pick_hit   = 1'b0;
    assign data_o     = m_data_i;
`endif

    // -----------------------------------------------------------------------
    // FSM next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        request_d = m_request_o;
        addr_d    = m_addr_o;
        sel_d     = m_sel_o;

        unique case (state_q)
            RDARB_IDLE: begin
                // The pick is re-evaluated every cycle; nothing is latched
                // while the reader is busy, so a withdrawn request is skipped.
                if (pick_hit) begin
                    // Hits never touch the reader, so busy does not block them.
                    grant_d = pick_grant;
                    state_d = RDARB_HIT;
                end else if (pick_any && !m_busy_i) begin
                    grant_d   = pick_grant;
                    addr_d    = addr_i[pick_idx];
                    sel_d     = sel_i[pick_idx];
                    request_d = 1'b1;
                    state_d   = RDARB_WAIT_ACK;
                end
            end
            RDARB_WAIT_ACK: begin
                if (m_ack_i) begin
                    request_d = 1'b0;
                    ptr_d     = ptr_next;
                    state_d   = RDARB_IDLE;
                end
            end
`ifdef GFX256_RDARB_CACHE_EN
            RDARB_HIT: begin
                ptr_d   = ptr_next;
                state_d = RDARB_IDLE;
            end
`endif
            default: begin
                request_d = 1'b0;
                state_d   = RDARB_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // loads values computed from the pre-edge state, independent of order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= RDARB_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            m_request_o <= 1'b0;
            m_addr_o    <= '0;
            m_sel_o     <= 32'hFFFF_FFFF;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            m_request_o <= request_d;
            m_addr_o    <= addr_d;
            m_sel_o     <= sel_d;
        end
    end

    // -----------------------------------------------------------------------
    // Ack path: combinational, zero cycles from m_ack_i.
    // -----------------------------------------------------------------------
    always_comb begin
        ack_o = '0;
        if (state_q == RDARB_WAIT_ACK && m_ack_i) ack_o = grant_q;
`ifdef GFX256_RDARB_CACHE_EN
        if (state_q == RDARB_HIT) ack_o = grant_q;
`endif
    end

endmodule
